// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - two-client arbiter feeding the tx frame buffer, start strobe and end/timeout wait
// Grants one client, writes length header plus payload, starts tx, then holds a guard gap.
module tx_scheduler #(
  parameter int          MAX_LEN      = 122,
  parameter int          ARB_MODE     = 0,
  parameter int          GUARD        = 16,
  parameter logic [23:0] TIMEOUT      = 24'd1000000,
  parameter logic [2:0]  TX_EVENT_END = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  i_req,
  input  logic [13:0] i_len,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_valid,
  output logic [1:0]  o_ready,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_buf_w_en,
  output logic [6:0]  o_buf_w_addr,
  output logic [7:0]  o_buf_byte,
  output logic        o_start,
  input  logic [2:0]  i_ev,
  input  logic        i_ev_sig
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_START,
    S_WAIT_END,
    S_GUARD
  } state_t;

  localparam logic [6:0]  MAX_L      = 7'(MAX_LEN);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD - 1);
  localparam logic [23:0] TO_LAST    = TIMEOUT - 24'd1;

  state_t      state, state_n;
  logic [6:0]  len_q, len_n;
  logic [6:0]  cnt, cnt_n;
  logic [23:0] tcnt, tcnt_n;
  logic [7:0]  gcnt, gcnt_n;
  logic        last_q, last_n;
  logic [1:0]  gnt_n, done_n;
  logic        err_n, w_en_n, start_n, busy_n;
  logic [6:0]  addr_n;
  logic [7:0]  byte_n;
  logic        win;
  logic        sel;

  // index of the granted client; o_gnt is one-hot while a transaction is live
  assign sel     = o_gnt[1];
  assign o_ready = o_gnt & {2{state == S_LOAD}};

  always_comb begin
    state_n = state;
    len_n   = len_q;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    gcnt_n  = gcnt;
    last_n  = last_q;
    gnt_n   = o_gnt;
    done_n  = 2'b00;
    err_n   = 1'b0;
    w_en_n  = 1'b0;
    addr_n  = o_buf_w_addr;
    byte_n  = o_buf_byte;
    start_n = 1'b0;
    win     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|i_req) begin
          if (&i_req) win = (ARB_MODE == 1) ? ~last_q : 1'b0;
          else        win = i_req[1];
          gnt_n   = win ? 2'b10 : 2'b01;
          len_n   = win ? i_len[13:7] : i_len[6:0];
          state_n = S_HDR;
        end
      end
      S_HDR: begin
        if (len_q == 7'd0 || len_q > MAX_L) begin
          done_n  = o_gnt;
          err_n   = 1'b1;
          gnt_n   = 2'b00;
          last_n  = sel;
          gcnt_n  = 8'd0;
          state_n = S_GUARD;
        end else begin
          // header carries the payload length plus the two FCS bytes
          w_en_n  = 1'b1;
          addr_n  = 7'd0;
          byte_n  = {1'b0, len_q} + 8'd2;
          cnt_n   = 7'd1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_valid[sel] && o_ready[sel]) begin
          w_en_n = 1'b1;
          addr_n = cnt;
          byte_n = sel ? i_data[15:8] : i_data[7:0];
          cnt_n  = cnt + 7'd1;
          if (cnt == len_q) state_n = S_START;
        end
      end
      S_START: begin
        start_n = 1'b1;
        tcnt_n  = 24'd0;
        state_n = S_WAIT_END;
      end
      S_WAIT_END: begin
        tcnt_n = tcnt + 24'd1;
        // a real end event takes precedence over a coincident timeout
        if (i_ev_sig && i_ev == TX_EVENT_END) begin
          done_n  = o_gnt;
          gnt_n   = 2'b00;
          last_n  = sel;
          gcnt_n  = 8'd0;
          state_n = S_GUARD;
        end else if (tcnt == TO_LAST) begin
          done_n  = o_gnt;
          err_n   = 1'b1;
          gnt_n   = 2'b00;
          last_n  = sel;
          gcnt_n  = 8'd0;
          state_n = S_GUARD;
        end
      end
      S_GUARD: begin
        if (gcnt == GUARD_LAST) state_n = S_IDLE;
        else                    gcnt_n  = gcnt + 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len_q        <= 7'd0;
      cnt          <= 7'd0;
      tcnt         <= 24'd0;
      gcnt         <= 8'd0;
      last_q       <= 1'b0;
      o_gnt        <= 2'b00;
      o_done       <= 2'b00;
      o_err        <= 1'b0;
      o_busy       <= 1'b0;
      o_buf_w_en   <= 1'b0;
      o_buf_w_addr <= 7'd0;
      o_buf_byte   <= 8'd0;
      o_start      <= 1'b0;
    end else begin
      state        <= state_n;
      len_q        <= len_n;
      cnt          <= cnt_n;
      tcnt         <= tcnt_n;
      gcnt         <= gcnt_n;
      last_q       <= last_n;
      o_gnt        <= gnt_n;
      o_done       <= done_n;
      o_err        <= err_n;
      o_busy       <= busy_n;
      o_buf_w_en   <= w_en_n;
      o_buf_w_addr <= addr_n;
      o_buf_byte   <= byte_n;
      o_start      <= start_n;
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb/tb_tx_scheduler.sv - directed self-checking bench for tx_scheduler
// Instance a: fixed priority, GUARD 16; instance b: round-robin, GUARD 4; both TIMEOUT 50.
module tb_tx_scheduler;

  localparam int         GUARD_A = 16;
  localparam int         GUARD_B = 4;
  localparam logic [2:0] EV_END  = 3'd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_req, a_valid, a_ready, a_gnt, a_done;
  logic [13:0] a_len;
  logic [15:0] a_data;
  logic        a_err, a_busy, a_w_en, a_start, a_ev_sig;
  logic [6:0]  a_addr;
  logic [7:0]  a_byte;
  logic [2:0]  a_ev;

  logic [1:0]  b_req, b_valid, b_ready, b_gnt, b_done;
  logic [13:0] b_len;
  logic [15:0] b_data;
  logic        b_err, b_busy, b_w_en, b_start, b_ev_sig;
  logic [6:0]  b_addr;
  logic [7:0]  b_byte;
  logic [2:0]  b_ev;

  tx_scheduler #(.MAX_LEN(122), .ARB_MODE(0), .GUARD(GUARD_A), .TIMEOUT(24'd50), .TX_EVENT_END(EV_END)) dut_a (
    .clk(clk), .reset(reset), .i_req(a_req), .i_len(a_len), .i_data(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_gnt(a_gnt), .o_done(a_done), .o_err(a_err), .o_busy(a_busy),
    .o_buf_w_en(a_w_en), .o_buf_w_addr(a_addr), .o_buf_byte(a_byte), .o_start(a_start),
    .i_ev(a_ev), .i_ev_sig(a_ev_sig));

  tx_scheduler #(.MAX_LEN(122), .ARB_MODE(1), .GUARD(GUARD_B), .TIMEOUT(24'd50), .TX_EVENT_END(EV_END)) dut_b (
    .clk(clk), .reset(reset), .i_req(b_req), .i_len(b_len), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_gnt(b_gnt), .o_done(b_done), .o_err(b_err), .o_busy(b_busy),
    .o_buf_w_en(b_w_en), .o_buf_w_addr(b_addr), .o_buf_byte(b_byte), .o_start(b_start),
    .i_ev(b_ev), .i_ev_sig(b_ev_sig));

  int checks = 0;
  int failures = 0;

  // buffer-port monitor for instance a
  int         cyc = 0, nwr = 0, nstart = 0, b2b = 0, last_wr_cyc = -1, start_cyc = -1;
  logic       prev_wen = 1'b0;
  logic [6:0] last_addr = 7'd0;
  logic [7:0] mem [0:127];

  always @(negedge clk) begin
    cyc++;
    if (a_w_en) begin
      mem[a_addr] = a_byte;
      nwr++;
      last_addr = a_addr;
      last_wr_cyc = cyc;
      if (prev_wen && a_addr > 7'd1) b2b++;
    end
    prev_wen = a_w_en;
    if (a_start) begin
      nstart++;
      start_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 64 && a_busy; i++) step();
    chk(tag, 32'(a_busy), 32'd0);
  endtask

  task automatic wait_idle_b(input string tag);
    for (int i = 0; i < 64 && b_busy; i++) step();
    chk(tag, 32'(b_busy), 32'd0);
  endtask

  task automatic load_a(input int c, input logic [6:0] n, input logic [7:0] base, input bit toggle);
    int k;
    bit x;
    a_len[7*c +: 7] = n;
    a_req[c] = 1'b1;
    step();
    chk("load_gnt", 32'(a_gnt), 32'(1) << c);
    a_req = 2'b00;
    k = 0;
    for (int i = 0; i < 400 && k < 32'(n); i++) begin
      a_valid[c] = toggle ? ~a_valid[c] : 1'b1;
      a_data[8*c +: 8] = base + 8'(k);
      x = a_valid[c] && a_ready[c];
      step();
      if (x) k++;
    end
    a_valid = 2'b00;
    chk("load_count", k, 32'(n));
    for (int i = 0; i < 4 && !a_start; i++) step();
    chk("load_start", 32'(a_start), 32'd1);
  endtask

  task automatic send_end_a(input logic [1:0] exp);
    a_ev = EV_END;
    a_ev_sig = 1'b1;
    step();
    a_ev_sig = 1'b0;
    a_ev = 3'd0;
    chk("end_done", 32'(a_done), 32'(exp));
    chk("end_err", 32'(a_err), 32'd0);
    chk("end_gnt", 32'(a_gnt), 32'd0);
  endtask

  task automatic err_frame_a(input logic [1:0] req, input logic [13:0] len, input logic [1:0] exp, input string tag);
    int w0, s0;
    w0 = nwr;
    s0 = nstart;
    a_len = len;
    a_req = req;
    step();
    chk({tag, "_gnt"}, 32'(a_gnt), 32'(exp));
    a_req = 2'b00;
    step();
    chk({tag, "_done"}, 32'(a_done), 32'(exp));
    chk({tag, "_err"}, 32'(a_err), 32'd1);
    chk({tag, "_gnt_clr"}, 32'(a_gnt), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(a_done), 32'd0);
    chk({tag, "_err_pulse"}, 32'(a_err), 32'd0);
    wait_idle_a({tag, "_idle"});
    chk({tag, "_no_wr"}, nwr - w0, 32'd0);
    chk({tag, "_no_start"}, nstart - s0, 32'd0);
  endtask

  task automatic err_frame_b(input logic [1:0] exp, input string tag);
    b_len = 14'd0;
    b_req = 2'b11;
    step();
    chk({tag, "_gnt"}, 32'(b_gnt), 32'(exp));
    b_req = 2'b00;
    step();
    chk({tag, "_done"}, 32'(b_done), 32'(exp));
    chk({tag, "_err"}, 32'(b_err), 32'd1);
    wait_idle_b({tag, "_idle"});
  endtask

  initial begin
    int w0, b0, s0, n, e;
    a_req = 2'b00; a_len = 14'd0; a_data = 16'd0; a_valid = 2'b00; a_ev = 3'd0; a_ev_sig = 1'b0;
    b_req = 2'b00; b_len = 14'd0; b_data = 16'd0; b_valid = 2'b00; b_ev = 3'd0; b_ev_sig = 1'b0;
    for (int j = 0; j < 128; j++) mem[j] = 8'h00;

    #2;
    chk("rst_gnt", 32'(a_gnt), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_wen", 32'(a_w_en), 32'd0);
    chk("rst_start", 32'(a_start), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // client 1, three bytes, continuous valid
    w0 = nwr;
    load_a(1, 7'd3, 8'hA1, 1'b0);
    step();
    chk("t1_nwr", nwr - w0, 32'd4);
    chk("t1_hdr", 32'(mem[0]), 32'h05);
    chk("t1_b1", 32'(mem[1]), 32'hA1);
    chk("t1_b2", 32'(mem[2]), 32'hA2);
    chk("t1_b3", 32'(mem[3]), 32'hA3);
    chk("t1_last_addr", 32'(last_addr), 32'd3);
    chk("t1_start_lat", start_cyc - last_wr_cyc, 32'd1);
    chk("t1_start_pulse", 32'(a_start), 32'd0);
    send_end_a(2'b10);
    step();
    chk("t1_done_pulse", 32'(a_done), 32'd0);
    repeat (GUARD_A - 2) step();
    chk("t1_busy_guard", 32'(a_busy), 32'd1);
    step();
    chk("t1_busy_low", 32'(a_busy), 32'd0);

    // arbitration ties
    err_frame_a(2'b11, 14'd0, 2'b01, "a_tie1");
    err_frame_a(2'b11, 14'd0, 2'b01, "a_tie2");
    err_frame_b(2'b10, "b_tie1");
    err_frame_b(2'b01, "b_tie2");
    err_frame_b(2'b10, "b_tie3");

    // rejected lengths
    err_frame_a(2'b01, {7'd0, 7'd0}, 2'b01, "a_len0");
    err_frame_a(2'b01, {7'd0, 7'd123}, 2'b01, "a_len123");

    // maximum length with valid toggling
    w0 = nwr;
    b0 = b2b;
    for (int j = 0; j < 128; j++) mem[j] = 8'h00;
    load_a(0, 7'd122, 8'h01, 1'b1);
    step();
    chk("t4_nwr", nwr - w0, 32'd123);
    chk("t4_last_addr", 32'(last_addr), 32'd122);
    chk("t4_hdr", 32'(mem[0]), 32'd124);
    chk("t4_gap_wen", b2b - b0, 32'd0);
    e = 0;
    for (int j = 1; j <= 122; j++) if (mem[j] !== 8'(j)) e++;
    chk("t4_payload", e, 32'd0);
    send_end_a(2'b01);
    wait_idle_a("t4_idle");

    // timeout with non-end events during the wait
    load_a(1, 7'd1, 8'h33, 1'b0);
    for (n = 0; n < 100 && a_done == 2'b00; n++) begin
      a_ev_sig = 1'b1;
      a_ev = n[0] ? 3'd2 : 3'd7;
      step();
    end
    a_ev_sig = 1'b0;
    a_ev = 3'd0;
    chk("t5_latency", n, 32'd50);
    chk("t5_done", 32'(a_done), 32'b10);
    chk("t5_err", 32'(a_err), 32'd1);
    a_ev = EV_END;
    a_ev_sig = 1'b1;
    step();
    chk("t5_guard_ev", 32'(a_done), 32'd0);
    a_ev_sig = 1'b0;
    wait_idle_a("t5_idle");
    a_ev_sig = 1'b1;
    step();
    chk("t5_idle_ev_done", 32'(a_done), 32'd0);
    chk("t5_idle_ev_busy", 32'(a_busy), 32'd0);
    a_ev_sig = 1'b0;
    a_ev = 3'd0;

    // end event coincides with timeout
    load_a(0, 7'd2, 8'h40, 1'b0);
    repeat (49) step();
    chk("t6_not_yet", 32'(a_done), 32'd0);
    a_ev = EV_END;
    a_ev_sig = 1'b1;
    step();
    a_ev_sig = 1'b0;
    a_ev = 3'd0;
    chk("t6_done", 32'(a_done), 32'b01);
    chk("t6_err", 32'(a_err), 32'd0);
    wait_idle_a("t6_idle");

    // asynchronous reset in LOAD after two bytes
    s0 = nstart;
    a_len = {7'd0, 7'd5};
    a_req = 2'b01;
    step();
    a_req = 2'b00;
    a_valid[0] = 1'b1;
    a_data[7:0] = 8'h77;
    step();
    step();
    step();
    #3;
    reset = 1'b1;
    #1;
    chk("t7_gnt", 32'(a_gnt), 32'd0);
    chk("t7_ready", 32'(a_ready), 32'd0);
    chk("t7_busy", 32'(a_busy), 32'd0);
    chk("t7_wen", 32'(a_w_en), 32'd0);
    chk("t7_addr", 32'(a_addr), 32'd0);
    chk("t7_byte", 32'(a_byte), 32'd0);
    a_valid = 2'b00;
    step();
    reset = 1'b0;
    step();
    chk("t7_idle", 32'(a_busy), 32'd0);
    chk("t7_no_start", nstart - s0, 32'd0);
    err_frame_a(2'b10, 14'd0, 2'b10, "t7_regrant");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
